// File: rtl/definitions_pkg.sv
// Shared constants for the UART receive path.
// Top-level defaults for the receive byte buffer.
package definitions_pkg;

    localparam int RX_FIFO_DEPTH = 16;
    localparam int RX_FIFO_AFULL = 12;
    localparam int RX_BYTE_W     = 8;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the UART receive buffer.
// One synchronous write port, one asynchronous read port, no reset.
module uart_rx_fifo_mem
    import definitions_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [RX_BYTE_W-1:0] i_wr_data,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [RX_BYTE_W-1:0] o_rd_data
);

    logic [RX_BYTE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer fed by the UART receiver done/out pair.
// Edge-detects rx_done, stores bytes, reports level and sticky overflow.
module uart_rx_fifo
    import definitions_pkg::*;
#(
    parameter int DEPTH       = RX_FIFO_DEPTH,
    parameter int AFULL_LEVEL = RX_FIFO_AFULL
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    input  logic                     flush,
    input  logic                     ovf_clr,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL = CW'(AFULL_LEVEL);

    logic          r_done_q;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_push;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_drop;
    logic          w_empty;
    logic          w_full;
    logic [7:0]    w_mem_rd;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);

    // done stays high until the next start bit; only its rising edge is a byte
    assign w_push  = rx_done & ~r_done_q;
    assign w_pop   = ~w_empty & rd_ready & ~flush;
    assign w_wr_en = w_push & ~flush & (~w_full | w_pop);
    assign w_drop  = w_push & ~flush & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_done_q <= 1'b1;
        end else begin
            r_done_q <= rx_done;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_wr_en) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // a drop in the same cycle as ovf_clr keeps the flag set
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (rx_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rd)
    );

    assign rd_valid    = ~w_empty;
    assign rd_data     = w_empty ? 8'h00 : w_mem_rd;
    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= C_AFULL);
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo.
// Vector table for single-cycle behaviour, directed sequences for corners.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rstN;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       flush;
    logic       ovf_clr;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overflow;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH       (16),
        .AFULL_LEVEL (12)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .flush       (flush),
        .ovf_clr     (ovf_clr),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    typedef struct {
        logic       done;
        logic [7:0] data;
        logic       rdy;
        logic       fl;
        logic       oc;
        int         e_cnt;
        logic       e_val;
        logic [7:0] e_data;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[17];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".count"}, 32'(count), 0);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 0);
        chk({tag, ".rd_data"}, 32'(rd_data), 0);
        chk({tag, ".empty"}, 32'(empty), 1);
        chk({tag, ".full"}, 32'(full), 0);
        chk({tag, ".almost_full"}, 32'(almost_full), 0);
        chk({tag, ".overflow"}, 32'(overflow), 0);
    endtask

    task automatic push(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] e);
        chk({nm, ".valid"}, 32'(rd_valid), 1);
        chk({nm, ".data"}, 32'(rd_data), 32'(e));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        // done data rdy fl oc | cnt val data ovf
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0};
        vecs[2]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0};
        vecs[4]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0};
        vecs[5]  = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0};
        vecs[6]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 2, 1'b1, 8'h3C, 1'b0};
        vecs[7]  = '{1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h5A, 1'b0};
        vecs[8]  = '{1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h99, 1'b0};
        vecs[9]  = '{1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        vecs[12] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h22, 1'b0};
        vecs[13] = '{1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        vecs[14] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1, 1'b1, 8'h33, 1'b0};
        vecs[15] = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h33, 1'b0};
        vecs[16] = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};

        rstN     = 1'b0;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
        flush    = 1'b0;
        ovf_clr  = 1'b0;
        rd_ready = 1'b0;
        #12;
        chk_reset("reset");
        rstN = 1'b1;
        tick();

        foreach (vecs[i]) begin
            rx_done  = vecs[i].done;
            rx_data  = vecs[i].data;
            rd_ready = vecs[i].rdy;
            flush    = vecs[i].fl;
            ovf_clr  = vecs[i].oc;
            tick();
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d.valid", i), 32'(rd_valid), 32'(vecs[i].e_val));
            chk($sformatf("vec%0d.data", i), 32'(rd_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
        end
        rx_done  = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        ovf_clr  = 1'b0;
        tick();

        // level hold: one push for a long done pulse
        rx_done = 1'b1;
        rx_data = 8'h44;
        repeat (40) tick();
        chk("hold.count", 32'(count), 1);
        chk("hold.data", 32'(rd_data), 32'h44);
        rstN = 1'b0;
        #2;
        chk_reset("hold_rst");
        #3;
        rstN = 1'b1;
        repeat (3) tick();
        chk("hold_release.count", 32'(count), 0);
        rx_done = 1'b0;
        tick();
        chk("hold_low.count", 32'(count), 0);

        // fill to full
        for (int i = 0; i < 16; i++) begin
            rx_done = 1'b1;
            rx_data = 8'(i);
            tick();
            chk($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
            chk($sformatf("fill%0d.afull", i), 32'(almost_full),
                32'(i + 1 >= 12));
            chk($sformatf("fill%0d.full", i), 32'(full), 32'(i + 1 == 16));
            rx_done = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) pop_chk($sformatf("pop%0d", i), 8'(i));
        chk("pop4.count", 32'(count), 12);
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        chk("wrap.full", 32'(full), 1);
        chk("wrap.count", 32'(count), 16);

        // overflow
        push(8'hEE);
        chk("ovf.count", 32'(count), 16);
        chk("ovf.flag", 32'(overflow), 1);
        chk("ovf.head", 32'(rd_data), 32'h04);
        rx_done = 1'b1;
        rx_data = 8'hEF;
        ovf_clr = 1'b1;
        tick();
        rx_done = 1'b0;
        ovf_clr = 1'b0;
        chk("ovf_clr_drop.flag", 32'(overflow), 1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr.flag", 32'(overflow), 0);

        // push and pop together while full
        chk("pp_full.head", 32'(rd_data), 32'h04);
        rx_done  = 1'b1;
        rx_data  = 8'h77;
        rd_ready = 1'b1;
        tick();
        rx_done  = 1'b0;
        rd_ready = 1'b0;
        chk("pp_full.count", 32'(count), 16);
        chk("pp_full.ovf", 32'(overflow), 0);
        tick();
        for (int i = 5; i < 20; i++) pop_chk($sformatf("drain%0h", i), 8'(i));
        pop_chk("drain_last", 8'h77);
        chk("drain.empty", 32'(empty), 1);
        chk("drain.data", 32'(rd_data), 0);
        chk("drain.count", 32'(count), 0);

        // push and pop together at count 1
        push(8'h81);
        rx_done  = 1'b1;
        rx_data  = 8'h82;
        rd_ready = 1'b1;
        tick();
        rx_done  = 1'b0;
        rd_ready = 1'b0;
        chk("pp_one.count", 32'(count), 1);
        chk("pp_one.data", 32'(rd_data), 32'h82);
        tick();
        pop_chk("pp_one_pop", 8'h82);
        chk("pp_one.empty", 32'(empty), 1);

        // flush with count 5 and overflow set
        for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
        push(8'hEE);
        for (int i = 0; i < 11; i++) pop_chk($sformatf("fl_pop%0d", i),
                                             8'(8'hC0 + i));
        chk("pre_flush.count", 32'(count), 5);
        chk("pre_flush.ovf", 32'(overflow), 1);
        rx_done = 1'b1;
        rx_data = 8'hDD;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        rx_done = 1'b0;
        chk("flush.count", 32'(count), 0);
        chk("flush.ovf", 32'(overflow), 0);
        chk("flush.empty", 32'(empty), 1);
        chk("flush.valid", 32'(rd_valid), 0);
        tick();

        // async reset mid-stream
        push(8'h01);
        push(8'h02);
        push(8'h03);
        chk("mid.count", 32'(count), 3);
        rx_done  = 1'b1;
        rx_data  = 8'h04;
        rd_ready = 1'b1;
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        chk_reset("async_rst");
        rx_done  = 1'b0;
        rd_ready = 1'b0;
        #2;
        rstN = 1'b1;
        tick();
        tick();
        chk("post_rst.count", 32'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
